// File: rtl/traffic_phase_arbiter_if.sv
// traffic_phase_arbiter_if: request/lamp bundle between the sensor side and the phase arbiter.
//   req     sensor requests, one bit per approach (driven by master)
//   grant   one-hot approach owning the phase, 0 when idle
//   green   green lamp per approach
//   yellow  yellow lamp per approach
//   red     red lamp per approach
//   phase   0=IDLE, 1=GREEN, 2=YELLOW, 3=ALLRED
interface traffic_phase_arbiter_if #(
    parameter int unsigned N_ROADS = 4
);
    logic [N_ROADS-1:0] req;
    logic [N_ROADS-1:0] grant;
    logic [N_ROADS-1:0] green;
    logic [N_ROADS-1:0] yellow;
    logic [N_ROADS-1:0] red;
    logic [1:0]         phase;

    modport master (
        output req,
        input  grant,
        input  green,
        input  yellow,
        input  red,
        input  phase
    );

    modport slave (
        input  req,
        output grant,
        output green,
        output yellow,
        output red,
        output phase
    );
endinterface

// File: rtl/traffic_phase_arbiter.sv
// traffic_phase_arbiter: round-robin green-phase scheduler for N_ROADS approaches.
// Latches sensor requests, grants one approach at a time and sequences green (with
// rest-in-green extension), yellow and all-red clearance. Lamps decode from registers only.
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  slave side of traffic_phase_arbiter_if (req in; grant/lamps/phase out)
module traffic_phase_arbiter #(
    parameter int unsigned N_ROADS  = 4,
    parameter int unsigned T_GREEN  = 150000000,
    parameter int unsigned T_YELLOW = 50000000,
    parameter int unsigned T_ALLRED = 25000000,
    parameter int unsigned CNT_W    = 28
) (
    input  logic                     clk,
    input  logic                     rst,
    traffic_phase_arbiter_if.slave   bus
);
    localparam int unsigned PW = (N_ROADS > 1) ? $clog2(N_ROADS) : 1;
    localparam int unsigned TMax01 = (T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW;
    localparam int unsigned TMax   = (TMax01 > T_ALLRED) ? TMax01 : T_ALLRED;

    localparam logic [CNT_W-1:0] GreenLast  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] YellowLast = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AllRedLast = CNT_W'(T_ALLRED - 1);

    if (N_ROADS < 2 || N_ROADS > 8) begin : g_bad_roads
        $error("N_ROADS must be in 2..8");
    end
    if (T_GREEN < 1 || T_YELLOW < 1 || T_ALLRED < 1) begin : g_bad_times
        $error("all phase lengths must be at least 1 cycle");
    end
    if (((64'(TMax) - 64'd1) >> CNT_W) != 64'd0) begin : g_bad_cnt_w
        $error("CNT_W too narrow for the longest phase");
    end

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGreen  = 2'd1,
        StYellow = 2'd2,
        StAllRed = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [N_ROADS-1:0] grant_q, grant_d;
    logic [N_ROADS-1:0] pending_q, pending_d;
    logic [PW-1:0]      ptr_q, ptr_d;

    logic               win_found;
    logic [PW-1:0]      win_idx;
    logic               grant_edge;
    logic [N_ROADS-1:0] req_accept;

    logic [N_ROADS-1:0] green, yellow, red;

    // Round-robin winner: first pending bit at or above ptr, wrapping.
    always_comb begin
        int unsigned idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int unsigned i = 0; i < N_ROADS; i++) begin
            idx = (int'(ptr_q) + i) % N_ROADS;
            if (!win_found && pending_q[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            grant_q   <= '0;
            pending_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            grant_q   <= grant_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        grant_edge = 1'b0;

        // The road being served cannot re-queue itself until its lamp is red.
        req_accept = ((state_q == StGreen) || (state_q == StYellow)) ? ~grant_q : '1;

        unique case (state_q)
            StIdle: begin
                if (win_found) grant_edge = 1'b1;
            end
            StGreen: begin
                if (timer_q == GreenLast) begin
                    // Rest-in-green: timer stays saturated until someone else waits.
                    if (win_found) begin
                        state_d = StYellow;
                        timer_d = '0;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            StYellow: begin
                if (timer_q == YellowLast) begin
                    state_d = StAllRed;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            StAllRed: begin
                if (timer_q == AllRedLast) begin
                    if (win_found) begin
                        grant_edge = 1'b1;
                    end else begin
                        state_d = StIdle;
                        grant_d = '0;
                        timer_d = '0;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
        endcase

        pending_d = pending_q | (bus.req & req_accept);

        if (grant_edge) begin
            state_d            = StGreen;
            timer_d            = '0;
            grant_d            = '0;
            grant_d[win_idx]   = 1'b1;
            ptr_d              = (win_idx == PW'(N_ROADS - 1)) ? '0 : win_idx + PW'(1);
            // Clear wins over a simultaneous re-request from the winner.
            pending_d[win_idx] = 1'b0;
        end
    end

    // Output decode
    always_comb begin
        green  = '0;
        yellow = '0;
        red    = '1;
        unique case (state_q)
            StGreen: begin
                green = grant_q;
                red   = ~grant_q;
            end
            StYellow: begin
                yellow = grant_q;
                red    = ~grant_q;
            end
            default: ;
        endcase
    end

    assign bus.grant  = grant_q;
    assign bus.green  = green;
    assign bus.yellow = yellow;
    assign bus.red    = red;
    assign bus.phase  = state_q;
endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// tb_traffic_phase_arbiter: directed bench for traffic_phase_arbiter with
// N_ROADS=4, T_GREEN=4, T_YELLOW=2, T_ALLRED=1.
module tb_traffic_phase_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    logic started;

    traffic_phase_arbiter_if #(.N_ROADS(4)) bus ();

    traffic_phase_arbiter #(
        .N_ROADS (4),
        .T_GREEN (4),
        .T_YELLOW(2),
        .T_ALLRED(1),
        .CNT_W   (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       do_rst;
        logic [3:0] req;
        logic [1:0] phase;
        logic [3:0] grant;
        logic [3:0] green;
        logic [3:0] yellow;
        logic [3:0] red;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [3:0] q, logic [1:0] ph, logic [3:0] g,
                                logic [3:0] gr, logic [3:0] y, logic [3:0] rd);
        vec_t v;
        v.do_rst = r;
        v.req    = q;
        v.phase  = ph;
        v.grant  = g;
        v.green  = gr;
        v.yellow = y;
        v.red    = rd;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lamp sanity every cycle: exactly one lamp per road, at most one road non-red.
    always @(negedge clk) begin
        if (started) begin
            check("one_lamp_per_road",
                  {28'd0, (bus.green | bus.yellow | bus.red)
                          & ~(bus.green & bus.yellow) & ~(bus.green & bus.red)
                          & ~(bus.yellow & bus.red)},
                  32'hf);
            check("single_non_red", {31'd0, $countones(~bus.red) <= 1}, 32'd1);
        end
    end

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        started = 1'b0;
        rst     = 1'b1;
        bus.req = '0;

        // Single pulse from idle, then rest in green.
        vecs.push_back(mk(1'b1, 4'b0100, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b1111));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1'b0, 4'b0000, 2'd1, 4'b0100, 4'b0100, 4'b0000, 4'b1011));
        // Simultaneous 1001 pulse, ptr=0.
        vecs.push_back(mk(1'b1, 4'b1001, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b1111));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1'b0, 4'b0000, 2'd1, 4'b0001, 4'b0001, 4'b0000, 4'b1110));
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(1'b0, 4'b0000, 2'd2, 4'b0001, 4'b0000, 4'b0001, 4'b1110));
        vecs.push_back(mk(1'b0, 4'b0000, 2'd3, 4'b0001, 4'b0000, 4'b0000, 4'b1111));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1'b0, 4'b0000, 2'd1, 4'b1000, 4'b1000, 4'b0000, 4'b0111));
        // Own request during extension is ignored.
        vecs.push_back(mk(1'b0, 4'b1000, 2'd1, 4'b1000, 4'b1000, 4'b0000, 4'b0111));
        vecs.push_back(mk(1'b0, 4'b0000, 2'd1, 4'b1000, 4'b1000, 4'b0000, 4'b0111));
        // Road 1 arrives during extension: yellow on the following edge.
        vecs.push_back(mk(1'b0, 4'b0010, 2'd1, 4'b1000, 4'b1000, 4'b0000, 4'b0111));
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(1'b0, 4'b0000, 2'd2, 4'b1000, 4'b0000, 4'b1000, 4'b0111));
        vecs.push_back(mk(1'b0, 4'b0000, 2'd3, 4'b1000, 4'b0000, 4'b0000, 4'b1111));
        vecs.push_back(mk(1'b0, 4'b0000, 2'd1, 4'b0010, 4'b0010, 4'b0000, 4'b1101));

        // Reset with idle inputs for 50 cycles.
        do_reset();
        started = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            check($sformatf("idle%0d", i),
                  {14'd0, bus.phase, bus.grant, bus.green, bus.yellow, bus.red},
                  {14'd0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b1111});
        end

        // Table-driven vectors.
        foreach (vecs[i]) begin
            if (vecs[i].do_rst) do_reset();
            bus.req = vecs[i].req;
            tick();
            bus.req = '0;
            check($sformatf("row%0d", i),
                  {14'd0, bus.phase, bus.grant, bus.green, bus.yellow, bus.red},
                  {14'd0, vecs[i].phase, vecs[i].grant, vecs[i].green, vecs[i].yellow,
                   vecs[i].red});
        end

        // All requests held: grants 0,1,2,3,0, seven cycles each.
        do_reset();
        bus.req = 4'b1111;
        for (int e = 1; e <= 36; e++) begin
            logic [1:0] exp_ph;
            logic [3:0] exp_g;
            tick();
            if (e == 1) begin
                exp_ph = 2'd0;
                exp_g  = 4'b0000;
            end else begin
                int o;
                int k;
                o      = (e - 2) % 7;
                k      = ((e - 2) / 7) % 4;
                exp_g  = 4'b0001 << k;
                exp_ph = (o < 4) ? 2'd1 : (o < 6) ? 2'd2 : 2'd3;
            end
            check($sformatf("rr_edge%0d", e), {26'd0, bus.phase, bus.grant},
                  {26'd0, exp_ph, exp_g});
        end
        bus.req = '0;

        // Reset in the second yellow cycle with road 1 pending.
        do_reset();
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b0010;
        tick();
        bus.req = '0;
        check("pre_rst_green", {26'd0, bus.phase, bus.grant}, {26'd0, 2'd1, 4'b0001});
        for (int i = 0; i < 5; i++) tick();
        check("pre_rst_yellow2", {26'd0, bus.phase, bus.yellow}, {26'd0, 2'd2, 4'b0001});
        rst = 1'b1;
        #1;
        check("async_rst", {14'd0, bus.phase, bus.grant, bus.green, bus.yellow, bus.red},
              {14'd0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b1111});
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("post_rst_idle%0d", i), {26'd0, bus.phase, bus.grant},
                  {26'd0, 2'd0, 4'b0000});
        end

        started = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
